// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver:
// frame geometry, receiver state encoding and the parity mode with its
// helper function.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int IDX_W     = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_DATA     = 3'd2,
    ST_PARITY   = 3'd3,
    ST_STOP     = 3'd4,
    ST_BRK_WAIT = 3'd5
  } uart_state_e;

  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } parity_mode_e;

  localparam parity_mode_e PARITY_MODE = PAR_EVEN;

  // Parity bit the transmitter attaches to a data byte.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] data);
    return (^data) ^ (PARITY_MODE == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_receiver_rx_fsm.sv
// Receive sequencer: walks a frame bit by bit and raises one-cycle sample
// strobes (registered) carrying the sampled line value and the data index.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   rx_i              synchronized serial line
//   busy_o            a frame is being received (any state but IDLE)
//   data_stb_o        bit_o is data bit number idx_o
//   par_stb_o         bit_o is the parity bit
//   stop_stb_o        bit_o is the stop bit; frame complete
//   bit_o, idx_o      sampled value and its data index
module uart_receiver_rx_fsm
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             rx_i,
  output logic             busy_o,
  output logic             data_stb_o,
  output logic             par_stb_o,
  output logic             stop_stb_o,
  output logic             bit_o,
  output logic [IDX_W-1:0] idx_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT/2 - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  uart_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0] idx_q;
  logic [1:0]       settle_q;
  logic             armed_q;

  assign busy_o = (state_q != ST_IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      settle_q   <= '0;
      armed_q    <= 1'b0;
      data_stb_o <= 1'b0;
      par_stb_o  <= 1'b0;
      stop_stb_o <= 1'b0;
      bit_o      <= 1'b1;
      idx_o      <= '0;
    end else begin
      data_stb_o <= 1'b0;
      par_stb_o  <= 1'b0;
      stop_stb_o <= 1'b0;

      // The synchronizer holds its reset value for two cycles after reset,
      // so the line is only trusted from the third cycle on. A frame may
      // start only after a genuine high has been seen, which turns a line
      // held low across reset into "no edge" rather than a false start.
      if (settle_q != 2'd2) settle_q <= settle_q + 2'd1;
      if (settle_q == 2'd2 && rx_i) armed_q <= 1'b1;

      unique case (state_q)
        ST_IDLE: begin
          if (armed_q && !rx_i) begin
            state_q <= ST_START;
            cnt_q   <= '0;
          end
        end
        ST_START: begin
          if (cnt_q == HALF_CNT) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= rx_i ? ST_IDLE : ST_DATA;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (cnt_q == FULL_CNT) begin
            cnt_q      <= '0;
            data_stb_o <= 1'b1;
            bit_o      <= rx_i;
            idx_o      <= idx_q;
            if (idx_q == LAST_IDX) state_q <= ST_PARITY;
            else                   idx_q   <= idx_q + IDX_W'(1);
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_PARITY: begin
          if (cnt_q == FULL_CNT) begin
            cnt_q     <= '0;
            par_stb_o <= 1'b1;
            bit_o     <= rx_i;
            state_q   <= ST_STOP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_STOP: begin
          if (cnt_q == FULL_CNT) begin
            cnt_q      <= '0;
            stop_stb_o <= 1'b1;
            bit_o      <= rx_i;
            // A low stop bit is a break: wait for the line to recover so
            // the still-low line is not taken as the next start bit.
            state_q    <= rx_i ? ST_IDLE : ST_BRK_WAIT;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_BRK_WAIT: begin
          if (rx_i) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: start, 8 data bits LSB first, even parity, one stop bit.
// Holds the last byte with its error flags until the consumer reads it.
// Ports:
//   CLK, RST     clock, synchronous active-high reset
//   RX_in        asynchronous serial line, idle high
//   RX_read      consumer acknowledge pulse for RX_data
//   RX_data      last received byte
//   RX_valid     RX_data not yet read
//   RX_busy      frame reception in progress
//   parity_err   parity mismatch on RX_data
//   frame_err    stop bit of RX_data was low
//   overrun      sticky: an unread byte was overwritten
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 RX_in,
  input  logic                 RX_read,
  output logic [DATA_BITS-1:0] RX_data,
  output logic                 RX_valid,
  output logic                 RX_busy,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  logic                 sync1_q, sync2_q;
  logic                 data_stb, par_stb, stop_stb, smp_bit;
  logic [IDX_W-1:0]     smp_idx;

  logic [DATA_BITS-1:0] shreg_q;
  logic                 par_q;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 read_ok;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= RX_in;
      sync2_q <= sync1_q;
    end
  end

  uart_receiver_rx_fsm #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx_fsm (
    .clk_i      (CLK),
    .rst_i      (RST),
    .rx_i       (sync2_q),
    .busy_o     (RX_busy),
    .data_stb_o (data_stb),
    .par_stb_o  (par_stb),
    .stop_stb_o (stop_stb),
    .bit_o      (smp_bit),
    .idx_o      (smp_idx)
  );

  // Assembly registers are pure data; every bit is rewritten each frame,
  // so a frame cut short by reset leaves nothing that reaches the outputs.
  always_ff @(posedge CLK) begin
    if (data_stb) shreg_q[smp_idx] <= smp_bit;
    if (par_stb)  par_q            <= smp_bit;
  end

  assign read_ok = RX_read && valid_q;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;
    if (stop_stb) begin
      data_d  = shreg_q;
      perr_d  = parity_of(shreg_q) ^ par_q;
      ferr_d  = ~smp_bit;
      valid_d = 1'b1;
    end else if (read_ok) begin
      valid_d = 1'b0;
    end
    // A load that lands together with a read replaces the byte cleanly.
    if (stop_stb && valid_q && !RX_read) ovr_d = 1'b1;
    else if (read_ok)                    ovr_d = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign RX_data    = data_q;
  assign RX_valid   = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_receiver.sv
module tb_uart_receiver;

  localparam int CPB = 16;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_in;
  logic       RX_read;
  logic [7:0] RX_data;
  logic       RX_valid, RX_busy, parity_err, frame_err, overrun;

  uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_in      (RX_in),
    .RX_read    (RX_read),
    .RX_data    (RX_data),
    .RX_valid   (RX_valid),
    .RX_busy    (RX_busy),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       exp_perr;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive start + data + parity + stop, one bit per CPB cycles.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    logic [10:0] bits;
    bits = {s, p, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      RX_in = bits[i];
      repeat (CPB) @(negedge CLK);
    end
    RX_in = 1'b1;
  endtask

  task automatic do_read();
    RX_read = 1'b1;
    @(negedge CLK);
    RX_read = 1'b0;
  endtask

  // Wait (bounded) for a byte, then compare it against the oldest expectation.
  task automatic check_out(input string tag);
    exp_t e;
    int   k;
    k = 0;
    while (!RX_valid && k < 40) begin
      @(negedge CLK);
      k++;
    end
    check({tag, " valid"}, RX_valid, 1'b1);
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s scoreboard: got empty queue, expected an entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, " data"}, RX_data, e.data);
      check({tag, " parity_err"}, parity_err, e.perr);
      check({tag, " frame_err"}, frame_err, e.ferr);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " RX_data"}, RX_data, 8'h00);
    check({tag, " RX_valid"}, RX_valid, 1'b0);
    check({tag, " RX_busy"}, RX_busy, 1'b0);
    check({tag, " parity_err"}, parity_err, 1'b0);
    check({tag, " frame_err"}, frame_err, 1'b0);
    check({tag, " overrun"}, overrun, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    logic seen;
    logic [10:0] bits;

    vecs[0] = '{8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h01, 1'b0, 1'b1};
    vecs[2] = '{8'h01, 1'b1, 1'b0};
    vecs[3] = '{8'hFF, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 1'b0, 1'b1};
    vecs[5] = '{8'h00, 1'b1, 1'b1};

    RST = 1'b1; RX_in = 1'b1; RX_read = 1'b0;
    repeat (4) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check_reset_vals("reset");
    repeat (10) @(negedge CLK);

    foreach (vecs[i]) begin
      sb.push_back('{vecs[i].data, vecs[i].exp_perr, 1'b0});
      send_frame(vecs[i].data, vecs[i].par, 1'b1);
      check_out($sformatf("vec%0d", i));
      repeat (4) @(negedge CLK);
      check($sformatf("vec%0d busy idle", i), RX_busy, 1'b0);
      do_read();
      check($sformatf("vec%0d read clears valid", i), RX_valid, 1'b0);
      repeat (3) @(negedge CLK);
    end

    // Read with nothing pending changes nothing.
    do_read();
    check("idle read valid", RX_valid, 1'b0);
    check("idle read data hold", RX_data, 8'h00);
    check("idle read perr hold", parity_err, 1'b1);

    // Break: stop bit low, line held low 40 cycles.
    sb.push_back('{8'h3C, 1'b0, 1'b1});
    bits = {1'b0, 1'b0, 8'h3C, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RX_in = bits[i];
      repeat (CPB) @(negedge CLK);
    end
    RX_in = 1'b0;
    repeat (40) @(negedge CLK);
    check_out("break");
    check("break busy held", RX_busy, 1'b1);
    RX_in = 1'b1;
    repeat (6) @(negedge CLK);
    check("break busy released", RX_busy, 1'b0);
    do_read();
    repeat (5) @(negedge CLK);

    // Glitch: 4 low cycles must be rejected as a false start.
    seen = 1'b0;
    RX_in = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (i == 4) RX_in = 1'b1;
      @(negedge CLK);
      if (RX_busy) seen = 1'b1;
    end
    check("glitch busy pulse", seen, 1'b1);
    repeat (30) @(negedge CLK);
    check("glitch busy idle", RX_busy, 1'b0);
    check("glitch no valid", RX_valid, 1'b0);

    // Overrun: two bytes with no read in between.
    sb.push_back('{8'h11, 1'b0, 1'b0});
    send_frame(8'h11, 1'b0, 1'b1);
    check_out("ovr first");
    check("ovr first overrun", overrun, 1'b0);
    repeat (3) @(negedge CLK);
    sb.push_back('{8'h22, 1'b0, 1'b0});
    send_frame(8'h22, 1'b0, 1'b1);
    check_out("ovr second");
    check("ovr set", overrun, 1'b1);
    do_read();
    check("ovr read valid", RX_valid, 1'b0);
    check("ovr read clears", overrun, 1'b0);
    repeat (5) @(negedge CLK);

    // Reset in the middle of data bit 3 of 0xFF.
    bits = {1'b1, 1'b0, 8'hFF, 1'b0};
    for (int i = 0; i < 4; i++) begin
      RX_in = bits[i];
      repeat (CPB) @(negedge CLK);
    end
    RX_in = 1'b1;
    repeat (CPB/2) @(negedge CLK);
    check("midframe busy", RX_busy, 1'b1);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    check_reset_vals("midframe reset");
    repeat (20) @(negedge CLK);
    check("post reset busy", RX_busy, 1'b0);
    check("post reset valid", RX_valid, 1'b0);
    sb.push_back('{8'h5A, 1'b0, 1'b0});
    send_frame(8'h5A, 1'b0, 1'b1);
    check_out("post reset frame");

    check("scoreboard drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, meaning CLK cycles per serial bit (even, >=4).
REQ-002 SHALL have port CLK  input  1  the single clock; all logic on its rising edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port RX_in  input  1  asynchronous serial line, idle high.
REQ-005 SHALL have port RX_read  input  1  consumer pulse acknowledging RX_data.
REQ-006 SHALL have port RX_data  output  8  last received byte.
REQ-007 SHALL have port RX_valid  output  1  RX_data holds an unread byte.
REQ-008 SHALL have port RX_busy  output  1  frame reception in progress.
REQ-009 SHALL have port parity_err  output  1  even-parity mismatch on the byte in RX_data.
REQ-010 SHALL have port frame_err  output  1  stop bit sampled low on the byte in RX_data.
REQ-011 SHALL have port overrun  output  1  sticky: an unread byte was overwritten.

Function
REQ-012 SHALL receive frames of start(0), 8 data bits LSB first, even parity bit, stop(1), matching the team transmitter.
REQ-013 SHALL pass RX_in through a 2-flop synchronizer (both flops reset to 1); all decisions use the synchronized value.
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP, BRK_WAIT, with a bit-cycle counter and a 3-bit data index.
REQ-015 IDLE: synchronized line 0 -> START, counter cleared.
REQ-016 START: at count CLKS_PER_BIT/2-1 sample; sample 1 -> IDLE (false start, no output change); sample 0 -> DATA, counter cleared.
REQ-017 DATA: sample at count CLKS_PER_BIT-1 (mid-bit), shift into bit[index]; after index 7 -> PARITY.
REQ-018 PARITY: sample mid-bit; mismatch when XOR of 8 data bits and parity bit = 1.
REQ-019 STOP: sample mid-bit; the cycle after the sample, load RX_data, parity_err, frame_err, set RX_valid; stop=1 -> IDLE; stop=0 -> BRK_WAIT.
REQ-020 BRK_WAIT: remain until synchronized line = 1, then IDLE.
REQ-021 RX_busy SHALL be 1 in START, DATA, PARITY, STOP, BRK_WAIT; 0 in IDLE.
REQ-022 RX_read with RX_valid=1 SHALL clear RX_valid next cycle; RX_read with RX_valid=0 is ignored; RX_data/errors hold until the next load.
REQ-023 Load with RX_valid=1 and no RX_read the same cycle SHALL set overrun; load and RX_read in the same cycle -> new byte loaded, RX_valid stays 1, no overrun.
REQ-024 overrun SHALL clear only on an RX_read accepted while no overrunning load occurs that cycle.
REQ-025 Counter SHALL wrap to 0 after each mid-bit sample; no sample is taken twice per bit.

Reset
REQ-026 RST SHALL force IDLE, counters 0, synchronizer 1, RX_data=8'h00, RX_valid=0, RX_busy=0, parity_err=0, frame_err=0, overrun=0, including mid-frame (partial byte discarded).
REQ-027 After RST deasserts, a frame SHALL be accepted only on a new falling edge seen after reset.

Structure
REQ-028 State encoding, frame length constants (DATA_BITS=8) and parity mode SHALL live in a shared UART package used by both transmitter and receiver.
REQ-029 One sub-module SHALL be used: RX_FSM (state, counters, sample strobes); the shift register, parity check and output buffer SHALL sit in uart_receiver.

Verification (CLKS_PER_BIT=16)
REQ-030 Frame 0xA5, parity 0, stop 1 -> RX_data=8'hA5, RX_valid=1, parity_err=0, frame_err=0, RX_busy low by IDLE.
REQ-031 Frame 0x01 with parity bit 0 -> RX_data=8'h01, parity_err=1, frame_err=0.
REQ-032 Frame 0x3C with stop 0, line held low 40 cycles -> frame_err=1, RX_busy=1 until line high, then IDLE.
REQ-033 RX_in low for 4 cycles only -> RX_busy pulses, returns to IDLE, RX_valid stays 0.
REQ-034 Frames 0x11 then 0x22 without RX_read -> RX_data=8'h22, overrun=1; RX_read -> RX_valid=0, overrun=0.
REQ-035 RST asserted during DATA bit 3 of 0xFF -> all outputs at reset values; following clean frame 0x5A received correctly.
